// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with a one-entry valid/ready output register.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   serial     raw UART line (idle high, asynchronous to clk)
//   data[7:0]  received byte, stable while valid=1
//   valid      byte available in the output register
//   ready      consumer accept (handshake on valid && ready)
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while output register still held; new byte dropped
module uart_rx #(
    parameter int unsigned DIVIDER = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVIDER / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] divcnt, divcnt_nxt;
    logic [2:0]       bitidx, bitidx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             byte_done, byte_done_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt, frame_err_nxt, overrun_nxt;
    logic             sync1, rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial;
            rx_s  <= sync1;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        divcnt_nxt    = divcnt;
        bitidx_nxt    = bitidx;
        shift_nxt     = shift;
        byte_done_nxt = 1'b0;
        data_nxt      = data;
        valid_nxt     = valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                divcnt_nxt = '0;
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (divcnt == HALF_LAST) begin
                    divcnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt  = S_DATA;
                        bitidx_nxt = '0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    divcnt_nxt = divcnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (divcnt == BIT_LAST) begin
                    divcnt_nxt        = '0;
                    shift_nxt[bitidx] = rx_s;
                    bitidx_nxt        = bitidx + 3'(1);
                    if (bitidx == 3'd7) state_nxt = S_STOP;
                end else begin
                    divcnt_nxt = divcnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leaves at mid stop bit so an immediately following start bit is seen.
                if (divcnt == BIT_LAST) begin
                    divcnt_nxt = '0;
                    if (rx_s) begin
                        byte_done_nxt = 1'b1;
                        state_nxt     = S_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_WAIT_HIGH;
                    end
                end else begin
                    divcnt_nxt = divcnt + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                divcnt_nxt = '0;
                if (rx_s) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt  = S_IDLE;
                divcnt_nxt = '0;
            end
        endcase

        // Output register: a completing byte loads unless the held byte is not being taken.
        if (byte_done) begin
            if (!valid || ready) begin
                data_nxt  = shift;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (valid && ready) begin
            valid_nxt = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            divcnt    <= '0;
            bitidx    <= '0;
            shift     <= '0;
            byte_done <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            divcnt    <= divcnt_nxt;
            bitidx    <= bitidx_nxt;
            shift     <= shift_nxt;
            byte_done <= byte_done_nxt;
            data      <= data_nxt;
            valid     <= valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at DIVIDER=8.
module tb_uart_rx;

    localparam int unsigned D = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Event tallies collected from the output pins.
    int         n_fe = 0;
    int         n_ov = 0;
    int         n_vrise = 0;
    int         n_both = 0;
    logic       valid_q = 1'b0;
    logic [7:0] got[$];

    int lat = 80;

    uart_rx #(.DIVIDER(D)) dut (
        .clk(clk), .rst_n(rst_n), .serial(serial), .data(data), .valid(valid),
        .ready(ready), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid && ready) got.push_back(data);
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        if (frame_err && overrun) n_both++;
        if (valid && !valid_q) n_vrise++;
        valid_q = valid;
    end

    // Drives one 8N1 frame starting at the current negedge; returns on a negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic release_line);
        serial = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial = b[i];
            repeat (D) @(negedge clk);
        end
        serial = stop_bit;
        repeat (D) @(negedge clk);
        if (release_line) serial = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; serial = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h want=00", data); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe got=%b want=0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ov got=%b want=0", overrun); end
        rst_n = 1'b1;
        repeat (2 * D) @(negedge clk);
    endtask

    task automatic test_basic();
        int cnt = 0;
        int fe0 = n_fe, ov0 = n_ov;
        ready = 1'b1;
        @(negedge clk);
        fork
            send_byte(8'hA5, 1'b1, 1'b1);
            begin
                for (cnt = 1; cnt <= 200; cnt++) begin
                    @(negedge clk);
                    if (valid) break;
                end
            end
        join_any
        n_cmp++; if (cnt < 78 || cnt > 80) begin n_err++; $display("FAIL basic_latency got=%0d want=78..80", cnt); end
        else lat = cnt;
        n_cmp++; if (data !== 8'hA5) begin n_err++; $display("FAIL basic_data got=%h want=a5", data); end
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_1cyc got=%b want=0", valid); end
        wait fork;
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (n_fe != fe0 || n_ov != ov0) begin n_err++; $display("FAIL basic_pulses fe=%0d ov=%0d want=0/0", n_fe - fe0, n_ov - ov0); end
    endtask

    task automatic test_overrun();
        int ov0 = n_ov, fe0 = n_fe;
        ready = 1'b0;
        @(negedge clk);
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'hC3, 1'b1, 1'b1);
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got=%b want=1", valid); end
        n_cmp++; if (data !== 8'h3C) begin n_err++; $display("FAIL ovr_data got=%h want=3c", data); end
        n_cmp++; if (n_ov - ov0 != 1) begin n_err++; $display("FAIL ovr_count got=%0d want=1", n_ov - ov0); end
        n_cmp++; if (n_fe != fe0) begin n_err++; $display("FAIL ovr_fe got=%0d want=0", n_fe - fe0); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_ack_valid got=%b want=0", valid); end
    endtask

    task automatic test_frame_err();
        int fe0 = n_fe, vr0 = n_vrise;
        ready = 1'b1;
        got.delete();
        @(negedge clk);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        serial = 1'b1;
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (n_fe - fe0 != 1) begin n_err++; $display("FAIL fe_count got=%0d want=1", n_fe - fe0); end
        n_cmp++; if (n_vrise != vr0) begin n_err++; $display("FAIL fe_novalid got=%0d want=0", n_vrise - vr0); end
        send_byte(8'h81, 1'b1, 1'b1);
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h81) begin n_err++; $display("FAIL fe_next_byte n=%0d got=%h want=81", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
        n_cmp++; if (n_fe - fe0 != 1) begin n_err++; $display("FAIL fe_count_after got=%0d want=1", n_fe - fe0); end
    endtask

    task automatic test_glitch();
        int fe0 = n_fe, ov0 = n_ov, vr0 = n_vrise;
        ready = 1'b1;
        got.delete();
        @(negedge clk);
        serial = 1'b0;
        repeat (2) @(negedge clk);
        serial = 1'b1;
        repeat (3 * D) @(negedge clk);
        n_cmp++; if (n_fe != fe0 || n_ov != ov0 || n_vrise != vr0) begin n_err++; $display("FAIL glitch_quiet fe=%0d ov=%0d vr=%0d want=0/0/0", n_fe - fe0, n_ov - ov0, n_vrise - vr0); end
        send_byte(8'h0F, 1'b1, 1'b1);
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (got.size() != 1 || got[0] !== 8'h0F) begin n_err++; $display("FAIL glitch_next_byte n=%0d got=%h want=0f", got.size(), (got.size() > 0) ? got[0] : 8'hxx); end
    endtask

    task automatic test_reset_mid();
        int fe0 = n_fe, ov0 = n_ov, vr0 = n_vrise;
        logic [7:0] ff = 8'hFF;
        ready = 1'b0;
        @(negedge clk);
        serial = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial = ff[i];
            repeat (D) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            n_err++; $display("FAIL rstmid_outputs data=%h v=%b fe=%b ov=%b want=00/0/0/0", data, valid, frame_err, overrun); end
        repeat (3) @(negedge clk);
        serial = 1'b1;
        rst_n = 1'b1;
        repeat (12 * D) @(negedge clk);
        n_cmp++; if (n_fe != fe0 || n_ov != ov0 || n_vrise != vr0) begin n_err++; $display("FAIL rstmid_quiet fe=%0d ov=%0d vr=%0d want=0/0/0", n_fe - fe0, n_ov - ov0, n_vrise - vr0); end
        send_byte(8'h12, 1'b1, 1'b1);
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || data !== 8'h12) begin n_err++; $display("FAIL rstmid_byte v=%b data=%h want=1/12", valid, data); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_simul();
        int ov0 = n_ov;
        ready = 1'b0;
        @(negedge clk);
        send_byte(8'h11, 1'b1, 1'b1);
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (valid !== 1'b1 || data !== 8'h11) begin n_err++; $display("FAIL simul_first v=%b data=%h want=1/11", valid, data); end
        fork
            send_byte(8'h22, 1'b1, 1'b1);
            begin
                repeat (lat - 1) @(negedge clk);
                ready = 1'b1;
                n_cmp++; if (valid !== 1'b1 || data !== 8'h11) begin n_err++; $display("FAIL simul_before v=%b data=%h want=1/11", valid, data); end
                @(negedge clk);
                ready = 1'b0;
                n_cmp++; if (valid !== 1'b1 || data !== 8'h22) begin n_err++; $display("FAIL simul_after v=%b data=%h want=1/22", valid, data); end
            end
        join
        repeat (2 * D) @(negedge clk);
        n_cmp++; if (n_ov != ov0) begin n_err++; $display("FAIL simul_overrun got=%0d want=0", n_ov - ov0); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    // Random frames with random stop validity and gaps (including zero) checked against a byte queue model.
    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe = 0;
        int fe0 = n_fe, ov0 = n_ov;
        ready = 1'b1;
        got.delete();
        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            logic [7:0] b = 8'($urandom);
            logic ok = ($urandom_range(0, 3) != 0);
            send_byte(b, ok, 1'b1);
            if (ok) begin
                exp_q.push_back(b);
                repeat ($urandom_range(0, 2) * D) @(negedge clk);
            end else begin
                exp_fe++;
                repeat (D * (1 + $urandom_range(0, 1))) @(negedge clk);
            end
        end
        repeat (3 * D) @(negedge clk);
        n_cmp++; if (got.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_byte[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (n_fe - fe0 != exp_fe) begin n_err++; $display("FAIL rand_fe got=%0d want=%0d", n_fe - fe0, exp_fe); end
        n_cmp++; if (n_ov != ov0) begin n_err++; $display("FAIL rand_ov got=%0d want=0", n_ov - ov0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_simul();
        test_random();
        n_cmp++; if (n_both != 0) begin n_err++; $display("FAIL err_exclusive got=%0d want=0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 asynchronous serial receiver; the receive-side counterpart of the UartTx block on the ulx3s board support.
- Samples the serial input at a fixed clocks-per-bit rate and reassembles bytes, LSB first.
- Presents each byte on a one-entry valid/ready output register to on-chip consumers.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DIVIDER, 25000000/115200 (217), clock cycles per bit period; legal range >= 4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- serial  input  1  raw UART line; idle high; asynchronous to clk.
- data  output  8  received byte; stable while valid=1.
- valid  output  1  byte available in the output register.
- ready  input  1  consumer accept; handshake completes on a cycle where valid && ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while the output register is still held; the new byte is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: data=0, valid=0, frame_err=0, overrun=0.
  - Internal: FSM=IDLE, divcnt=0, bitidx=0, shift register=0, synchronizer flops=1.
  - Deassertion of rst_n is taken synchronously on the next clk edge.
  - Reset mid-frame abandons the frame; no output pulses are generated.
- Input synchronizer: two flops on serial produce rx_s; this adds 2 cycles of latency. All decisions use rx_s only.
- divcnt: 32-bit counter, cleared on every state transition and after every bit sample.
- FSM states and transitions:
  - IDLE: when rx_s==0, go to START with divcnt=0.
  - START: count to DIVIDER/2-1 (integer division).
    - If rx_s==0 at that count: go to DATA, divcnt=0, bitidx=0.
    - If rx_s==1 at that count: glitch; return to IDLE with no pulse.
  - DATA: at divcnt==DIVIDER-1, sample rx_s into shift[bitidx] (LSB first) and increment bitidx. After bitidx 7 is sampled, go to STOP.
  - STOP: at divcnt==DIVIDER-1, sample rx_s.
    - rx_s==1: complete the byte, go to IDLE.
    - rx_s==0: pulse frame_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. A held-low break line therefore yields exactly one frame_err.
- Resulting sample point: mid-bit for all data and stop bits.
- Byte completion: the cycle after the stop sample, check the output register.
  - If valid==0, or valid && ready in that same cycle: load data=shift and set valid=1 on the next edge. On a simultaneous handshake, valid stays 1 with the new data.
  - Else: pulse overrun for 1 cycle; data and valid are unchanged.
- Handshake: valid && ready with no byte completing in that cycle clears valid on the next edge. data holds its last value after valid falls.
- Byte latency: valid rises 2 (sync) + DIVIDER/2 + 9*DIVIDER + 1 cycles (±1) after the serial start-bit falling edge.
- Error pulses: frame_err and overrun are never asserted together. Each is high for exactly one cycle per event.
- Back-to-back frames: IDLE is re-entered before the nominal stop-bit end, so a start bit immediately following a stop bit is detected.

Test Plan:
- DIVIDER=8, send 0xA5 with a correct stop bit, ready=1 -> valid high for exactly 1 cycle with data=0xA5; first valid 2+4+72+1 cycles (±1) after the start edge; no frame_err or overrun.
- DIVIDER=8, ready=0, send 0x3C then 0xC3 back-to-back -> valid=1 with data=0x3C held; one overrun pulse at the end of the 0xC3 frame; data stays 0x3C. Then ready=1 for 1 cycle -> valid=0.
- Send 0x55 with the stop bit driven low, then hold the line low for 40 cycles, then release high -> exactly one frame_err pulse; valid stays 0; the next frame 0x81 is received correctly.
- 2-cycle low glitch on serial while idle (DIVIDER=8) -> return to IDLE; no valid, frame_err, or overrun; the following frame 0x0F is received correctly.
- Drive rst_n low mid-frame (after 4 data bits of 0xFF), release, then send 0x12 -> all outputs are 0 during reset; after release, data=0x12 with valid set, and no pulses from the aborted frame.
- Byte completes while valid=1 and ready=1 in the same cycle (0x11 pending, 0x22 arriving) -> valid stays 1, data changes 0x11->0x22, no overrun.
